// File: rtl/sys_ctrl_bus_arbiter.sv
// sys_ctrl_bus_arbiter
// Shares the CPU/VRAM memory bus between the CPU core and the debug port
// that sys_ctrl_fsm drives. It runs the halt handshake with the CPU, moves
// bus ownership between the two sides, and returns debug read data with a
// one-cycle valid strobe.
//
// Optional build macro: SYS_CTRL_BUS_WPROT_EN
//   When defined, this adds the WPROT_BASE parameter and the sticky
//   wprot_hit output. Debug writes at or above WPROT_BASE are then blocked.
module sys_ctrl_bus_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned RD_LAT       = 1,
`ifdef SYS_CTRL_BUS_WPROT_EN
    parameter logic [ADDR_W-1:0] WPROT_BASE = 'h8000,
`endif
    parameter int unsigned HALT_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_halt_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_we,
    input  logic              dbg_re,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic              dbg_granted,
    output logic              dbg_busy,
    output logic              halt_timeout,
`ifdef SYS_CTRL_BUS_WPROT_EN
    output logic              wprot_hit,
`endif
    input  logic [ADDR_W-1:0] cpu_bus_addr,
    input  logic [DATA_W-1:0] cpu_bus_wdata,
    input  logic              cpu_bus_we,
    output logic [DATA_W-1:0] cpu_bus_rdata,
    output logic              cpu_halt,
    input  logic              cpu_is_halted,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [2:0]       RD_LAST = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        CPU_OWN,
        HALT_WAIT,
        DBG_IDLE,
        DBG_READ,
        RELEASE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  to_cnt;
    logic [2:0]        rd_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              read_go;
    logic              dbg_wr_ok;
    logic              dbg_wr_prot;

    assign rd_last = (state == DBG_READ) && (rd_cnt == RD_LAST);
    assign read_go = (state == DBG_IDLE) && dbg_halt_req && dbg_re && !dbg_we;

`ifdef SYS_CTRL_BUS_WPROT_EN
    assign dbg_wr_prot = (dbg_addr >= WPROT_BASE);
`else
    assign dbg_wr_prot = 1'b0;
`endif
    assign dbg_wr_ok = (state == DBG_IDLE) && dbg_we && !dbg_wr_prot;

    // Ownership and status flags come straight from the state register.
    assign cpu_halt      = (state == HALT_WAIT) || (state == DBG_IDLE) || (state == DBG_READ);
    assign dbg_granted   = (state == DBG_IDLE) || (state == DBG_READ);
    assign dbg_busy      = (state == DBG_READ);
    assign cpu_bus_rdata = mem_rdata;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CPU_OWN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the ownership handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            CPU_OWN: begin
                if (dbg_halt_req) state_nxt = HALT_WAIT;
            end
            HALT_WAIT: begin
                if (!dbg_halt_req)      state_nxt = RELEASE;
                else if (cpu_is_halted) state_nxt = DBG_IDLE;
            end
            DBG_IDLE: begin
                if (!dbg_halt_req) state_nxt = RELEASE;
                else if (read_go)  state_nxt = DBG_READ;
            end
            DBG_READ: begin
                // A read that is already in flight always completes before release.
                if (rd_last) state_nxt = dbg_halt_req ? DBG_IDLE : RELEASE;
            end
            RELEASE: begin
                if (dbg_halt_req)        state_nxt = HALT_WAIT;
                else if (!cpu_is_halted) state_nxt = CPU_OWN;
            end
            default: state_nxt = CPU_OWN;
        endcase
    end

    // Halt-wait counter (saturating) and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt       <= '0;
            halt_timeout <= 1'b0;
        end else begin
            if (state == HALT_WAIT) begin
                if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
                if (!cpu_is_halted && (to_cnt == TO_LAST)) halt_timeout <= 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Debug read path: latch the address, count the latency, and capture the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr    <= '0;
            rd_cnt     <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            dbg_rvalid <= rd_last;
            if (read_go) begin
                rd_addr <= dbg_addr;
                rd_cnt  <= '0;
            end else if ((state == DBG_READ) && !rd_last) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (rd_last) dbg_rdata <= mem_rdata;
        end
    end

`ifdef SYS_CTRL_BUS_WPROT_EN
    // Sticky flag that records a blocked debug write; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wprot_hit <= 1'b0;
        end else if ((state == DBG_IDLE) && dbg_we && dbg_wr_prot) begin
            wprot_hit <= 1'b1;
        end
    end
`endif

    // Memory bus mux. While in DBG_IDLE the live dbg_addr is used so that a
    // write lands in the same cycle. The other debug states present the latched
    // read address.
    always_comb begin
        mem_addr  = cpu_bus_addr;
        mem_wdata = cpu_bus_wdata;
        mem_we    = cpu_bus_we;
        if ((state != CPU_OWN) && (state != HALT_WAIT)) begin
            mem_addr  = (state == DBG_IDLE) ? dbg_addr : rd_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_wr_ok;
        end
        if (!rst) mem_we = 1'b0;
    end

endmodule
